imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// little-endian, through a small word FIFO, with session state and bounds checking.
module imem_loader #(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MEM_BYTES  = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] word_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // FIFO: {last, word} per entry
    logic [32:0]      r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_last_seen;

    // byte writer: word being serialised, then a registered output stage
    logic        r_cur_valid;
    logic [1:0]  r_cur_idx;
    logic [31:0] r_cur_word;
    logic        r_cur_last;

    logic [31:0] r_ptr;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_out_word_end;
    logic        r_out_last;
    logic        r_overflow;
    logic [15:0] r_word_count;

    logic        w_start;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_in_ready;
    logic        w_push;
    logic        w_pop;
    logic [32:0] w_head;
    logic [31:0] w_byte_addr;
    logic        w_in_range;
    logic [7:0]  w_byte_data;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // start is only honoured outside LOAD; rst gates it through the async reset
    assign w_start      = start && (r_state != S_LOAD);
    assign w_fifo_full  = (r_count == CNT_FULL);
    assign w_fifo_empty = (r_count == '0);
    // No bypass: a full FIFO refuses a word even if a pop happens this cycle.
    assign w_in_ready   = (r_state == S_LOAD) && !w_fifo_full && !r_last_seen;
    assign w_push       = in_valid && w_in_ready;
    assign w_pop        = (r_state == S_LOAD) && !w_fifo_empty &&
                          (!r_cur_valid || (r_cur_idx == 2'd3));
    assign w_head       = r_fifo_mem[r_rd_ptr];

    assign w_byte_addr  = r_ptr + {30'd0, r_cur_idx};
    assign w_in_range   = ({1'b0, w_byte_addr} < 33'(MEM_BYTES));

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_byte_data = r_cur_word[7:0];
        unique case (r_cur_idx)
            2'd0:    w_byte_data = r_cur_word[7:0];
            2'd1:    w_byte_data = r_cur_word[15:8];
            2'd2:    w_byte_data = r_cur_word[23:16];
            default: w_byte_data = r_cur_word[31:24];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  if (r_out_word_end && r_out_last) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: the FIFO storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= {in_last, in_word};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_seen <= 1'b0;
        end else if (w_start) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_seen <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
                if (in_last) r_last_seen <= 1'b1;
            end
            if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_valid <= 1'b0;
            r_cur_idx   <= 2'd0;
            r_cur_word  <= '0;
            r_cur_last  <= 1'b0;
        end else if (w_start) begin
            r_cur_valid <= 1'b0;
            r_cur_idx   <= 2'd0;
        end else if (w_pop) begin
            r_cur_valid <= 1'b1;
            r_cur_idx   <= 2'd0;
            r_cur_word  <= w_head[31:0];
            r_cur_last  <= w_head[32];
        end else if (r_cur_valid) begin
            if (r_cur_idx == 2'd3) r_cur_valid <= 1'b0;
            else                   r_cur_idx   <= r_cur_idx + 2'd1;
        end
    end

    // Output stage: the byte slot is consumed even when out of range; only the strobe is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr          <= BASE_ADDR;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_out_word_end <= 1'b0;
            r_out_last     <= 1'b0;
            r_overflow     <= 1'b0;
            r_word_count   <= '0;
        end else if (w_start) begin
            r_ptr          <= BASE_ADDR;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_out_word_end <= 1'b0;
            r_out_last     <= 1'b0;
            r_overflow     <= 1'b0;
            r_word_count   <= '0;
        end else begin
            r_mem_we       <= r_cur_valid && w_in_range;
            r_out_word_end <= r_cur_valid && (r_cur_idx == 2'd3);
            r_out_last     <= r_cur_valid && (r_cur_idx == 2'd3) && r_cur_last;
            if (r_cur_valid) begin
                r_mem_addr  <= w_byte_addr;
                r_mem_wdata <= w_byte_data;
                if (!w_in_range)        r_overflow <= 1'b1;
                if (r_cur_idx == 2'd3)  r_ptr      <= r_ptr + 32'd4;
            end
            // a word counts once its byte 3 has been presented
            if (r_out_word_end && (r_word_count != 16'hFFFF))
                r_word_count <= r_word_count + 16'd1;
        end
    end

    assign in_ready   = w_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = (r_state == S_LOAD);
    assign done       = (r_state == S_DONE);
    assign overflow   = r_overflow;
    assign word_count = r_word_count;

endmodule
